// File: rtl/cmag_isqrt_pkg.sv
// Shared types and sizing for the complex-magnitude integer square-root stage.
package cmag_isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_DIN_WIDTH  = 64;
  localparam int DEFAULT_DOUT_WIDTH = DEFAULT_DIN_WIDTH / 2;
  localparam int DEFAULT_CNT_WIDTH  = $clog2(DEFAULT_DOUT_WIDTH);

  // Iteration counter must hold DOUT_WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int dout_width);
    return (dout_width > 1) ? $clog2(dout_width) : 1;
  endfunction

endpackage

// File: rtl/cmag_isqrt_step.sv
// One restoring square-root iteration: brings in two radicand bits, emits one root bit.
module cmag_isqrt_step #(
  parameter int W = 32
) (
  input  logic [W+1:0] rem_i,
  input  logic [W-1:0] root_i,
  input  logic [1:0]   bits_i,
  output logic [W+1:0] rem_o,
  output logic [W-1:0] root_o
);

  logic [W+1:0] rem_sh;
  logic [W+1:0] trial;
  logic         unused_rem_hi;

  // The running remainder never exceeds 2*root, so its top two bits are
  // always zero before the shift and can be dropped.
  assign rem_sh        = {rem_i[W-1:0], bits_i};
  assign trial         = {root_i, 2'b01};
  assign unused_rem_hi = ^rem_i[W+1:W];

  always_comb begin
    rem_o  = rem_sh;
    root_o = {root_i[W-2:0], 1'b0};
    if (rem_sh >= trial) begin
      rem_o  = rem_sh - trial;
      root_o = {root_i[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/cmag_isqrt_stream.sv
// AXI4-Stream integer sqrt, one root bit per cycle: result DOUT_WIDTH+1 cycles after accept, held until m_axis_tready.
// Input stalled (tready=0) while iterating; CMAG_ISQRT_ROUND_EN selects round-to-nearest instead of floor.
module cmag_isqrt_stream
  import cmag_isqrt_pkg::*;
#(
  parameter int DIN_WIDTH  = DEFAULT_DIN_WIDTH,
  parameter int DOUT_WIDTH = DIN_WIDTH / 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DIN_WIDTH-1:0]  s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DOUT_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int CNT_W = cnt_width(DOUT_WIDTH);

  state_e                state_q, state_d;
  logic [DIN_WIDTH-1:0]  rad_q, rad_d;
  logic [DOUT_WIDTH+1:0] rem_q, rem_d, step_rem;
  logic [DOUT_WIDTH-1:0] root_q, root_d, step_root;
  logic [DOUT_WIDTH-1:0] dat_q, dat_d, done_root;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  in_hs, out_hs;

  cmag_isqrt_step #(.W(DOUT_WIDTH)) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[DIN_WIDTH-1 -: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  assign s_axis_tready = ap_rst_n &&
                         ((state_q == IDLE) || ((state_q == DONE) && m_axis_tready));
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = (state_q == DONE) && m_axis_tready;

  assign m_axis_tvalid = (state_q == DONE);
  assign m_axis_tdata  = dat_q;
  assign m_axis_tlast  = last_q;

  // Final-iteration root as presented downstream; rounding saturates at all-ones.
  always_comb begin
    done_root = step_root;
`ifdef CMAG_ISQRT_ROUND_EN
    if ((step_rem > {2'b00, step_root}) && (step_root != '1)) begin
      done_root = step_root + DOUT_WIDTH'(1);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    dat_d   = dat_q;
    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          state_d = CALC;
          rad_d   = s_axis_tdata;
          last_d  = s_axis_tlast;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CNT_W'(DOUT_WIDTH - 1);
        end
      end
      CALC: begin
        rem_d  = step_rem;
        root_d = step_root;
        rad_d  = rad_q << 2;
        if (cnt_q == '0) begin
          state_d = DONE;
          dat_d   = done_root;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_hs) begin
          if (in_hs) begin
            state_d = CALC;
            rad_d   = s_axis_tdata;
            last_d  = s_axis_tlast;
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = CNT_W'(DOUT_WIDTH - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      dat_q   <= dat_d;
    end
  end

endmodule

// File: tb/tb_cmag_isqrt_stream.sv
// Scoreboard bench for cmag_isqrt_stream: random and directed radicands against an arithmetic sqrt model.
module tb_cmag_isqrt_stream;

  localparam int DIN  = 64;
  localparam int DOUT = 32;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n;
  logic [DIN-1:0]  s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            s_axis_tlast;
  logic [DOUT-1:0] m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;

  cmag_isqrt_stream #(.DIN_WIDTH(DIN), .DOUT_WIDTH(DOUT)) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [DOUT-1:0] root;
    logic            last;
    int              acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stall 10 cycles per result

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Floor square root by binary search on r*r <= x, optional round-to-nearest.
  function automatic logic [DOUT-1:0] ref_sqrt(input logic [DIN-1:0] x);
    longint unsigned lo, hi, mid, xv;
    xv = x;
    lo = 0;
    hi = 64'hFFFF_FFFF;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= xv) lo = mid;
      else hi = mid - 1;
    end
`ifdef CMAG_ISQRT_ROUND_EN
    if ((xv - lo * lo > lo) && (lo != 64'hFFFF_FFFF)) lo = lo + 1;
`endif
    return DOUT'(lo);
  endfunction

  task automatic send(input logic [DIN-1:0] x, input logic last, output int acc);
    bit   ok;
    exp_t e;
    ok  = 0;
    acc = -1;
    @(negedge ap_clk);
    s_axis_tdata  = x;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #4;
      if (s_axis_tready) begin
        ok        = 1;
        acc       = cyc;
        e.root    = ref_sqrt(x);
        e.last    = last;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
      end
      @(posedge ap_clk);
      if (ok) break;
      @(negedge ap_clk);
    end
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    @(negedge ap_clk);
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      @(negedge ap_clk);
    end
    if (!ok) fail_now("drain_timeout");
    repeat (3) @(negedge ap_clk);
  endtask

  // Monitor: latency, stability under stall, single transfer, scoreboard compare.
  logic [DOUT-1:0] held_dat;
  logic            held_last;
  bit              prev_vld = 0;
  bit              prev_hs = 0;
  int              stall_left = 0;

  initial begin
    exp_t e;
    bit   rdy;
    m_axis_tready = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        prev_vld      = 0;
        prev_hs       = 0;
        stall_left    = 0;
        m_axis_tready = 1'b0;
      end else begin
        if (prev_hs && m_axis_tvalid) fail_now("extra_transfer");
        if (m_axis_tvalid && !prev_vld) begin
          if (exp_q.size() == 0) fail_now("unexpected_output");
          else chk("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(DOUT + 1));
          if (rdy_mode == 2) stall_left = 10;
          held_dat  = m_axis_tdata;
          held_last = m_axis_tlast;
        end else if (m_axis_tvalid && prev_vld && !prev_hs) begin
          chk("stall_tdata", m_axis_tdata, held_dat);
          chk("stall_tlast", m_axis_tlast, held_last);
        end
        if (stall_left > 0) begin
          rdy = 0;
          stall_left--;
        end else if (rdy_mode == 1) begin
          rdy = ($urandom_range(0, 2) != 0);
        end else begin
          rdy = 1;
        end
        m_axis_tready = rdy;
        prev_vld = m_axis_tvalid;
        prev_hs  = m_axis_tvalid && rdy;
        if (m_axis_tvalid && !rdy) begin
          #1;
          chk("s_tready_in_stall", s_axis_tready, 1'b0);
        end
        if (prev_hs && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tdata", m_axis_tdata, e.root);
          chk("tlast", m_axis_tlast, e.last);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, acc;
    logic [DIN-1:0] x;
    ap_rst_n      = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(negedge ap_clk);
    chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_m_tdata", m_axis_tdata, '0);
    chk("rst_m_tlast", m_axis_tlast, 1'b0);
    chk("rst_s_tready", s_axis_tready, 1'b0);
    ap_rst_n = 1'b1;
    #1;
    chk("idle_s_tready", s_axis_tready, 1'b1);

    rdy_mode = 0;
    send(64'd25, 1'b1, acc);
    drain();
    send(64'd0, 1'b0, acc);
    send(64'd24, 1'b1, acc);
    send(64'd20, 1'b0, acc);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, acc);
    drain();

    send(64'd100, 1'b0, a0);
    send(64'd144, 1'b0, a1);
    send(64'd1_000_000_000_000, 1'b1, a2);
    chk("b2b_period_1", 64'(a1 - a0), 64'(DOUT + 1));
    chk("b2b_period_2", 64'(a2 - a1), 64'(DOUT + 1));
    drain();

    rdy_mode = 2;
    send(64'd1_000_000, 1'b1, acc);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 30; i++) begin
      x = {$urandom, $urandom};
      x = x >> $urandom_range(0, 63);
      send(x, 1'($urandom_range(0, 1)), acc);
      if ($urandom_range(0, 1) != 0) begin
        @(negedge ap_clk);
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge ap_clk);
      end
    end
    drain();

    rdy_mode = 0;
    send(64'd10000, 1'b1, acc);
    drain();
    send(64'd81, 1'b1, acc);
    @(negedge ap_clk);
    s_axis_tvalid = 1'b0;
    repeat (9) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("midrst_m_tdata", m_axis_tdata, '0);
    chk("midrst_m_tlast", m_axis_tlast, 1'b0);
    chk("midrst_s_tready", s_axis_tready, 1'b0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (45) @(negedge ap_clk);
    chk("post_rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("post_rst_s_tready", s_axis_tready, 1'b1);
    send(64'd49, 1'b1, acc);
    drain();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
